// File: rtl/rd_port_40x64b_1_to_8_arb.sv
// Read port for the 40x64 register file: round-robin arbitration of 8 requesters
// onto one read port, with a 3-stage pipe that returns data to the granted requester.
module rd_port_40x64b_1_to_8_arb #(
    parameter int NUM_PORTS   = 8,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 64,
    parameter int NUM_ENTRIES = 40
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    output logic [NUM_PORTS-1:0]          rd_ack,
    output logic [NUM_PORTS-1:0]          rd_data_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_err,
    output logic                          rf_rd_en,
    output logic [ADDR_W-1:0]             rf_rd_addr,
    output logic [NUM_PORTS-1:0]          rf_rd_select,
    input  logic [DATA_W-1:0]             rf_rd_data
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_ENTRIES);

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] eligible;
    logic                 grant_any;
    logic [PTR_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    grant_addr;
    logic                 in_range;
    int                   idx;

    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 en_q, en_d;
    logic                 s1_err_q, s1_err_d;
    logic [NUM_PORTS-1:0] s2_sel_q;
    logic                 s2_err_q;
    logic [NUM_PORTS-1:0] valid_q;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 err_q;

    // A requester acked this cycle sits out one cycle, so it cannot be granted twice in a row.
    assign eligible = req & ~ack_q;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        // Walk offsets from farthest to nearest so the nearest eligible port overrides.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_PORTS;
            if (eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
        in_range   = {1'b0, grant_addr} < LIMIT;
        ack_d      = grant_any ? (NUM_PORTS'(1) << grant_idx) : '0;
        addr_d     = grant_any ? grant_addr : '0;
        en_d       = grant_any & in_range;
        s1_err_d   = grant_any & ~in_range;
        ptr_d      = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
        // Out-of-range reads never touch the file, so return zero rather than whatever it drives.
        data_d = ((|s2_sel_q) && !s2_err_q) ? rf_rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            ack_q    <= '0;
            addr_q   <= '0;
            en_q     <= 1'b0;
            s1_err_q <= 1'b0;
            s2_sel_q <= '0;
            s2_err_q <= 1'b0;
            valid_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            s1_err_q <= s1_err_d;
            s2_sel_q <= ack_q;
            s2_err_q <= s1_err_q;
            valid_q  <= s2_sel_q;
            data_q   <= data_d;
            err_q    <= s2_err_q;
        end
    end

    assign rd_ack        = ack_q;
    assign rf_rd_select  = ack_q;
    assign rf_rd_addr    = addr_q;
    assign rf_rd_en      = en_q;
    assign rd_data_valid = valid_q;
    assign rd_data       = data_q;
    assign rd_err        = err_q;

endmodule

// File: doc/rd_port_40x64b_1_to_8_arb.md
Name: rd_port_40x64b_1_to_8_arb

Overview:
- Read-side counterpart of the 8-to-1 write port mux on the 40-entry x 64-bit register file.
- Accepts read requests from 8 independent requesters and arbitrates them round-robin onto the single register-file read port, one grant per cycle.
- Issues the granted address to the file, then routes the returned 64-bit data back to the granted requester with a valid pulse and an error flag.
- Sits between the exec-stage consumers and the register file.

Parameters:
- NUM_PORTS, 8, number of requesters; the grant vector is one-hot of this width.
- ADDR_W, 6, register-file address width.
- DATA_W, 64, register-file data width.
- NUM_ENTRIES, 40, valid address range 0..NUM_ENTRIES-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  bit i = requester i read request, level, held until acked.
- req_addr  input  48  requester i address at bits [6i+5:6i].
- rd_ack  output  8  one-hot pulse: request of requester i accepted.
- rd_data_valid  output  8  one-hot pulse: rd_data belongs to requester i.
- rd_data  output  64  returned data, broadcast to all requesters.
- rd_err  output  1  qualifies rd_data_valid: address was out of range.
- rf_rd_en  output  1  register-file read enable.
- rf_rd_addr  output  6  register-file read address.
- rf_rd_select  output  8  one-hot id of the requester owning the current rf_rd_en.
- rf_rd_data  input  64  register-file data, valid the cycle after rf_rd_en.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all pipeline valids cleared, round-robin pointer = 0. In-flight reads are discarded; no rd_data_valid is produced for them after reset release.
- Eligibility: requester i is eligible in cycle C iff req[i]=1 and rd_ack[i]=0 in C. A requester holding req after its ack is therefore re-arbitrated no earlier than C+1, giving a maximum rate of one read per 2 cycles per requester.
- Arbitration (combinational in cycle C):
  - Search eligible requesters starting at the pointer, ascending with wrap 7->0; first hit wins.
  - On a grant to i, the pointer becomes (i+1) mod 8 at the end of C.
  - No grant: pointer unchanged.
- Stage 1 (registered, visible in C+1):
  - rd_ack[i]=1 and rf_rd_select=onehot(i).
  - rf_rd_addr = req_addr[i] as sampled in C.
  - rf_rd_en=1 only if addr < NUM_ENTRIES; else rf_rd_en=0 and an error bit is carried down the pipe.
  - With no grant: rd_ack=0, rf_rd_select=0, rf_rd_en=0, rf_rd_addr=0.
- Stage 2: the file drives rf_rd_data in C+2; the block registers it at the end of C+2.
- Stage 3 (visible in C+3):
  - rd_data_valid[i]=1 with rd_data = captured data.
  - For an out-of-range request: rd_data=0, rd_err=1.
  - Otherwise rd_err=0. With no valid: rd_data_valid=0 and rd_data, rd_err hold 0.
- Latency: req rising in C -> rd_ack in C+1 -> rd_data_valid in C+3 (uncontended).
- Throughput: one grant per cycle across requesters; three reads may be in flight.
- Ordering: returns come back in grant order. rd_data_valid is never asserted to more than one requester per cycle.
- Request withdrawal: req dropped before the ack produces no grant. req dropped in the ack cycle does not cancel the accepted read.
- Address changes while req is held but not yet granted are legal; the address sampled in the grant cycle is used.
- rf_rd_select is always one-hot or zero, and is zero whenever rd_ack is zero.

Test Plan:
- Reset, then req=8'h04 with addr2=6'd17, file[17]=64'hDEAD_BEEF_0123_4567.
  -> rd_ack=8'h04 and rf_rd_addr=17 one cycle later; rd_data_valid=8'h04 with that data three cycles after the request; rd_err=0.
- All 8 requesters assert together in one cycle, addr i = i, pointer=0.
  -> acks 0,1,…,7 on consecutive cycles; data for file[0..7] returned in the same order, one per cycle.
- Requester 3 holds req continuously with constant addr 5.
  -> acks on alternate cycles only; rd_data_valid for port 3 on alternate cycles.
- Requester 1 requests addr 6'd40, requester 6 requests addr 6'd12 simultaneously.
  -> port 1 granted first with rf_rd_en=0; port 1 gets rd_data=0, rd_err=1; port 6 gets file[12] with rd_err=0 the next cycle.
- After a grant to port 5, ports 2 and 6 request together.
  -> port 6 is granted before port 2 (wrap check).
- Assert rst_n=0 one cycle after an ack to port 4, release after 2 cycles.
  -> no rd_data_valid for port 4 ever appears; all outputs 0 during and after reset until a new request arrives.
